// File: rtl/yuv420_unpack_pkg.sv
// Shared types and helpers for the packed YUV420 stream unpacker.
// Stream type codes match the packer side; an earlier dtypes definition wins.
`ifndef DTYPE_WIDTH
`define DTYPE_WIDTH        8
`define DTYPE_FRAME_START  8'h01
`define DTYPE_FRAME_END    8'h02
`define DTYPE_HEADER_START 8'h03
`define DTYPE_HEADER       8'h04
`define DTYPE_ROW_START    8'h05
`define DTYPE_ROW_END      8'h06
`define DTYPE_PIXEL        8'h10
`define DTYPE_PIXEL_MASK   8'hF0
`endif

package yuv420_unpack_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_HEADER = 3'd1;
    localparam logic [2:0] ST_HDR2   = 3'd2;
    localparam logic [2:0] ST_PIXELS = 3'd3;
    localparam logic [2:0] ST_FLUSH  = 3'd4;
    localparam logic [2:0] ST_DRAIN  = 3'd5;

    localparam logic [1:0] RP_START = 2'd0;
    localparam logic [1:0] RP_IN    = 2'd1;
    localparam logic [1:0] RP_END   = 2'd2;

    localparam logic [`DTYPE_WIDTH-1:0] DT_FRAME_START  = `DTYPE_FRAME_START;
    localparam logic [`DTYPE_WIDTH-1:0] DT_FRAME_END    = `DTYPE_FRAME_END;
    localparam logic [`DTYPE_WIDTH-1:0] DT_HEADER_START = `DTYPE_HEADER_START;
    localparam logic [`DTYPE_WIDTH-1:0] DT_HEADER       = `DTYPE_HEADER;
    localparam logic [`DTYPE_WIDTH-1:0] DT_ROW_START    = `DTYPE_ROW_START;
    localparam logic [`DTYPE_WIDTH-1:0] DT_ROW_END      = `DTYPE_ROW_END;
    localparam logic [`DTYPE_WIDTH-1:0] DT_PIXEL        = `DTYPE_PIXEL;

    typedef enum logic [3:0] {
        K_NONE, K_FSTART, K_FEND, K_HSTART, K_HDR_LO, K_HDR_HI,
        K_ROW_START, K_ROW_END, K_PIXEL
    } emit_kind_t;

    // Bytes consumed by the next pixel: chroma rides on odd pixels of odd rows in 420 mode.
    function automatic logic [3:0] token_size(input logic raw, input logic en,
                                              input logic row_phase, input logic col_phase);
        logic [3:0] size;
        if (raw) begin
            size = 4'd1;
        end else if (!en) begin
            size = 4'd3;
        end else if (row_phase && col_phase) begin
            size = 4'd3;
        end else begin
            size = 4'd1;
        end
        return size;
    endfunction

endpackage

// File: rtl/yuv420_unpack_byte_fifo8.sv
// Eight-byte shift buffer: appends 4-byte words, pops 1 or 3 oldest bytes.
// Bytes above the fill count are always zero so a push can simply OR in.
module yuv420_unpack_byte_fifo8 (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        push,
    input  logic [31:0] push_data,
    input  logic [1:0]  pop_cnt,
    output logic [3:0]  count,
    output logic [7:0]  byte0,
    output logic [7:0]  byte1,
    output logic [7:0]  byte2
);

    logic [63:0] data_r;
    logic [3:0]  count_r;
    logic [63:0] shifted_s;
    logic [63:0] next_data_s;
    logic [3:0]  remain_s;
    logic [3:0]  next_count_s;

    // Pop first, then append the new word right after whatever bytes remain.
    always_comb begin
        case (pop_cnt)
            2'd1:    shifted_s = {8'h00, data_r[63:8]};
            2'd3:    shifted_s = {24'h000000, data_r[63:24]};
            default: shifted_s = data_r;
        endcase
        remain_s = count_r - {2'b00, pop_cnt};
        if (push) begin
            next_data_s  = shifted_s | ({32'h00000000, push_data} << {remain_s, 3'b000});
            next_count_s = remain_s + 4'd4;
        end else begin
            next_data_s  = shifted_s;
            next_count_s = remain_s;
        end
    end

    // Buffer storage with async reset and synchronous flush.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_r  <= 64'h0;
            count_r <= 4'd0;
        end else if (clear) begin
            data_r  <= 64'h0;
            count_r <= 4'd0;
        end else begin
            data_r  <= next_data_s;
            count_r <= next_count_s;
        end
    end

    assign count = count_r;
    assign byte0 = data_r[7:0];
    assign byte1 = data_r[15:8];
    assign byte2 = data_r[23:16];

endmodule

// File: rtl/yuv420_unpack.sv
// Packed 32-bit YUV420 word stream back to one pixel per cycle with framing.
// Each cycle picks at most one output event; counters and outputs follow that choice.
module yuv420_unpack
    import yuv420_unpack_pkg::*;
#(
    parameter int NUM_COLS_WIDTH = 11,
    parameter int BUF_BYTES      = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [15:0]               image_type,
    input  logic                      enable,
    input  logic [NUM_COLS_WIDTH-1:0] num_cols,
    input  logic [NUM_COLS_WIDTH-1:0] num_rows,
    input  logic                      dvi,
    input  logic [`DTYPE_WIDTH-1:0]   dtypei,
    input  logic [31:0]               datai,
    output logic                      rdyo,
    output logic                      dvo,
    output logic [`DTYPE_WIDTH-1:0]   dtypeo,
    output logic [7:0]                yo,
    output logic [7:0]                uo,
    output logic [7:0]                vo,
    output logic                      uv_valid,
    output logic [15:0]               meta_datao
);

    localparam logic [3:0]                ACCEPT_MAX = 4'(BUF_BYTES - 4);
    localparam logic [NUM_COLS_WIDTH-1:0] CNT_ONE    = NUM_COLS_WIDTH'(1);

    logic [2:0]                state_r;
    logic                      raw_r;
    logic                      en_r;
    logic [NUM_COLS_WIDTH-1:0] cols_r;
    logic [NUM_COLS_WIDTH-1:0] rows_r;
    logic [NUM_COLS_WIDTH-1:0] col_r;
    logic [NUM_COLS_WIDTH-1:0] row_r;
    logic [1:0]                rphase_r;
    logic [15:0]               hdr_hi_r;

    logic                      dvo_r;
    logic [`DTYPE_WIDTH-1:0]   dtypeo_r;
    logic [7:0]                yo_r;
    logic [7:0]                uo_r;
    logic [7:0]                vo_r;
    logic                      uv_valid_r;
    logic [15:0]               meta_r;

    logic [3:0]  count_s;
    logic [7:0]  b0_s;
    logic [7:0]  b1_s;
    logic [7:0]  b2_s;
    logic        rdyo_s;
    logic        accept_s;
    logic        is_fs_s;
    logic        is_fe_s;
    logic        is_pix_s;
    logic [3:0]  tok_s;
    logic        pix_ok_s;
    logic        last_row_s;
    emit_kind_t  kind_s;
    logic [2:0]  nstate_s;
    logic        push_s;
    logic        clear_s;
    logic [1:0]  pop_s;

    yuv420_unpack_byte_fifo8 u_fifo (
        .clk       (clk),
        .reset     (reset),
        .clear     (clear_s),
        .push      (push_s),
        .push_data (datai),
        .pop_cnt   (pop_s),
        .count     (count_s),
        .byte0     (b0_s),
        .byte1     (b1_s),
        .byte2     (b2_s)
    );

    // Ready depends only on registered state and buffer fill.
    always_comb begin
        case (state_r)
            ST_PIXELS:         rdyo_s = (count_s <= ACCEPT_MAX);
            ST_HDR2, ST_FLUSH: rdyo_s = 1'b0;
            default:           rdyo_s = 1'b1;
        endcase
    end

    assign accept_s   = dvi && rdyo_s;
    assign is_fs_s    = accept_s && (dtypei == `DTYPE_FRAME_START);
    assign is_fe_s    = accept_s && (dtypei == `DTYPE_FRAME_END);
    assign is_pix_s   = |(dtypei & `DTYPE_PIXEL_MASK);
    assign tok_s      = token_size(raw_r, en_r, row_r[0], col_r[0]);
    assign pix_ok_s   = (count_s >= tok_s);
    assign last_row_s = (row_r == (rows_r - CNT_ONE));
    assign pop_s      = (kind_s == K_PIXEL) ? tok_s[1:0] : 2'd0;

    // Decide this cycle's output event, buffer action and next state.
    always_comb begin
        kind_s   = K_NONE;
        nstate_s = state_r;
        push_s   = 1'b0;
        clear_s  = 1'b0;
        if (is_fs_s) begin
            kind_s   = K_FSTART;
            clear_s  = 1'b1;
            nstate_s = ST_HEADER;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    kind_s = K_NONE;
                end
                ST_HEADER: begin
                    if (!accept_s) begin
                        kind_s = K_NONE;
                    end else if (dtypei == `DTYPE_HEADER_START) begin
                        kind_s = K_HSTART;
                    end else if (dtypei == `DTYPE_HEADER) begin
                        kind_s   = K_HDR_LO;
                        nstate_s = ST_HDR2;
                    end else if (is_pix_s) begin
                        push_s   = 1'b1;
                        nstate_s = ST_PIXELS;
                    end else if (is_fe_s) begin
                        kind_s   = K_FEND;
                        nstate_s = ST_IDLE;
                    end else begin
                        kind_s = K_NONE;
                    end
                end
                ST_HDR2: begin
                    kind_s   = K_HDR_HI;
                    nstate_s = ST_HEADER;
                end
                ST_PIXELS: begin
                    push_s = accept_s && is_pix_s;
                    case (rphase_r)
                        RP_START: kind_s = K_ROW_START;
                        RP_IN:    kind_s = pix_ok_s ? K_PIXEL : K_NONE;
                        RP_END:   kind_s = K_ROW_END;
                        default:  kind_s = K_NONE;
                    endcase
                    if (is_fe_s) begin
                        nstate_s = ST_FLUSH;
                    end else if ((rphase_r == RP_END) && last_row_s) begin
                        nstate_s = ST_DRAIN;
                    end else begin
                        nstate_s = state_r;
                    end
                end
                // Short frame: finish complete pixels, close the row, then end the frame.
                ST_FLUSH: begin
                    case (rphase_r)
                        RP_START: begin
                            if (pix_ok_s && (row_r < rows_r)) begin
                                kind_s = K_ROW_START;
                            end else begin
                                kind_s   = K_FEND;
                                nstate_s = ST_IDLE;
                            end
                        end
                        RP_IN:   kind_s = pix_ok_s ? K_PIXEL : K_ROW_END;
                        RP_END:  kind_s = K_ROW_END;
                        default: begin
                            kind_s   = K_FEND;
                            nstate_s = ST_IDLE;
                        end
                    endcase
                end
                ST_DRAIN: begin
                    clear_s = 1'b1;
                    if (is_fe_s) begin
                        kind_s   = K_FEND;
                        nstate_s = ST_IDLE;
                    end else begin
                        kind_s = K_NONE;
                    end
                end
                default: begin
                    nstate_s = ST_IDLE;
                end
            endcase
        end
    end

    // State, per-frame configuration and row/column progress.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r  <= ST_IDLE;
            raw_r    <= 1'b0;
            en_r     <= 1'b0;
            cols_r   <= '0;
            rows_r   <= '0;
            col_r    <= '0;
            row_r    <= '0;
            rphase_r <= RP_START;
            hdr_hi_r <= 16'h0000;
        end else begin
            state_r <= nstate_s;
            case (kind_s)
                K_FSTART: begin
                    raw_r    <= (image_type == 16'h0000);
                    en_r     <= enable;
                    cols_r   <= num_cols;
                    rows_r   <= num_rows;
                    col_r    <= '0;
                    row_r    <= '0;
                    rphase_r <= RP_START;
                end
                K_HDR_LO:    hdr_hi_r <= datai[31:16];
                K_ROW_START: rphase_r <= RP_IN;
                K_PIXEL: begin
                    if (col_r == (cols_r - CNT_ONE)) begin
                        col_r    <= '0;
                        rphase_r <= RP_END;
                    end else begin
                        col_r <= col_r + CNT_ONE;
                    end
                end
                K_ROW_END: begin
                    row_r    <= row_r + CNT_ONE;
                    rphase_r <= RP_START;
                end
                default: begin
                    rphase_r <= rphase_r;
                end
            endcase
        end
    end

    // Registered output stage; chroma holds its last value on Y-only pixels.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dvo_r      <= 1'b0;
            dtypeo_r   <= '0;
            yo_r       <= 8'h00;
            uo_r       <= 8'h00;
            vo_r       <= 8'h00;
            uv_valid_r <= 1'b0;
            meta_r     <= 16'h0000;
        end else begin
            dvo_r      <= (kind_s != K_NONE);
            uv_valid_r <= 1'b0;
            case (kind_s)
                K_FSTART:    dtypeo_r <= `DTYPE_FRAME_START;
                K_FEND:      dtypeo_r <= `DTYPE_FRAME_END;
                K_HSTART:    dtypeo_r <= `DTYPE_HEADER_START;
                K_HDR_LO: begin
                    dtypeo_r <= `DTYPE_HEADER;
                    meta_r   <= datai[15:0];
                end
                K_HDR_HI: begin
                    dtypeo_r <= `DTYPE_HEADER;
                    meta_r   <= hdr_hi_r;
                end
                K_ROW_START: dtypeo_r <= `DTYPE_ROW_START;
                K_ROW_END:   dtypeo_r <= `DTYPE_ROW_END;
                K_PIXEL: begin
                    dtypeo_r <= `DTYPE_PIXEL;
                    yo_r     <= b0_s;
                    if (tok_s == 4'd3) begin
                        uo_r       <= b1_s;
                        vo_r       <= b2_s;
                        uv_valid_r <= 1'b1;
                    end else begin
                        uv_valid_r <= 1'b0;
                    end
                end
                default: dtypeo_r <= dtypeo_r;
            endcase
        end
    end

    assign rdyo       = rdyo_s;
    assign dvo        = dvo_r;
    assign dtypeo     = dtypeo_r;
    assign yo         = yo_r;
    assign uo         = uo_r;
    assign vo         = vo_r;
    assign uv_valid   = uv_valid_r;
    assign meta_datao = meta_r;

endmodule

// File: tb/tb_yuv420_unpack.sv
// Directed bench for yuv420_unpack: output events are logged and compared in order.
module tb_yuv420_unpack;
    import yuv420_unpack_pkg::*;

    typedef struct packed {
        logic [31:0] cyc;
        logic [7:0]  dt;
        logic [7:0]  y;
        logic [7:0]  u;
        logic [7:0]  v;
        logic        uvv;
        logic [15:0] meta;
    } ev_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] image_type;
    logic        enable;
    logic [10:0] num_cols;
    logic [10:0] num_rows;
    logic        dvi;
    logic [7:0]  dtypei;
    logic [31:0] datai;
    logic        rdyo;
    logic        dvo;
    logic [7:0]  dtypeo;
    logic [7:0]  yo;
    logic [7:0]  uo;
    logic [7:0]  vo;
    logic        uv_valid;
    logic [15:0] meta_datao;

    int          checks = 0;
    int          errors = 0;
    int          rd_ptr = 0;
    int          rdy_low_cnt = 0;
    logic [31:0] cyc = 32'd0;
    logic [31:0] last_cyc;
    ev_t         evq[$];

    yuv420_unpack dut (
        .clk        (clk),
        .reset      (reset),
        .image_type (image_type),
        .enable     (enable),
        .num_cols   (num_cols),
        .num_rows   (num_rows),
        .dvi        (dvi),
        .dtypei     (dtypei),
        .datai      (datai),
        .rdyo       (rdyo),
        .dvo        (dvo),
        .dtypeo     (dtypeo),
        .yo         (yo),
        .uo         (uo),
        .vo         (vo),
        .uv_valid   (uv_valid),
        .meta_datao (meta_datao)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 32'd1;

    always @(negedge clk) begin
        if (dvo) evq.push_back({cyc, dtypeo, yo, uo, vo, uv_valid, meta_datao});
        if (dvi && !rdyo) rdy_low_cnt <= rdy_low_cnt + 1;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [7:0] dt, input logic [31:0] data);
        int n;
        n = 0;
        dvi = 1'b1;
        dtypei = dt;
        datai = data;
        @(negedge clk);
        while (!rdyo && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        assert (rdyo === 1'b1) else begin
            errors++;
            $error("FAIL send_ready: rdyo=%b expected 1 for dtype %h", rdyo, dt);
        end
        @(posedge clk);
        #1;
        dvi = 1'b0;
    endtask

    task automatic get_ev(input string tag, output ev_t e, output bit ok);
        int n;
        n = 0;
        while (evq.size() <= rd_ptr && n < 300) begin
            @(posedge clk);
            n++;
        end
        ok = (evq.size() > rd_ptr);
        checks++;
        assert (ok) else begin
            errors++;
            $error("FAIL %s: got %0d events, expected more than %0d", tag, evq.size(), rd_ptr);
        end
        if (ok) begin
            e = evq[rd_ptr];
            rd_ptr++;
            last_cyc = e.cyc;
        end else begin
            e = '0;
        end
    endtask

    task automatic expect_kind(input string tag, input logic [7:0] dt);
        ev_t e;
        bit  ok;
        get_ev(tag, e, ok);
        if (ok) begin
            checks++;
            assert (e.dt === dt) else begin
                errors++;
                $error("FAIL %s: dtypeo=%h expected %h", tag, e.dt, dt);
            end
        end
    endtask

    task automatic expect_pix(input string tag, input logic [7:0] y, input logic [7:0] u,
                              input logic [7:0] v, input logic uvv);
        ev_t         e;
        bit          ok;
        logic [32:0] obs;
        logic [32:0] exp_v;
        get_ev(tag, e, ok);
        if (ok) begin
            obs   = {e.dt, e.y, e.uvv, (uvv ? {e.u, e.v} : 16'h0000)};
            exp_v = {DT_PIXEL, y, uvv, (uvv ? {u, v} : 16'h0000)};
            checks++;
            assert (obs === exp_v) else begin
                errors++;
                $error("FAIL %s: dt/y/uv/u/v=%h expected %h", tag, obs, exp_v);
            end
        end
    endtask

    task automatic expect_meta(input string tag, input logic [15:0] meta);
        ev_t e;
        bit  ok;
        get_ev(tag, e, ok);
        if (ok) begin
            checks++;
            assert ({e.dt, e.meta} === {DT_HEADER, meta}) else begin
                errors++;
                $error("FAIL %s: dt/meta=%h expected %h", tag, {e.dt, e.meta}, {DT_HEADER, meta});
            end
        end
    endtask

    task automatic expect_quiet(input string tag);
        tick(20);
        checks++;
        assert (evq.size() === rd_ptr) else begin
            errors++;
            $error("FAIL %s: %0d extra events, expected 0", tag, evq.size() - rd_ptr);
        end
        rd_ptr = evq.size();
    endtask

    initial begin
        logic [31:0] c0;
        int          low0;
        reset = 1'b1;
        image_type = 16'h0001;
        enable = 1'b1;
        num_cols = 11'd4;
        num_rows = 11'd2;
        dvi = 1'b0;
        dtypei = 8'h00;
        datai = 32'h0;
        tick(2);
        @(negedge clk);
        checks++;
        assert ({dvo, dtypeo, yo, uo, vo, uv_valid, meta_datao, rdyo} === {1'b0, 8'h00, 24'h0, 1'b0, 16'h0, 1'b1})
        else begin
            errors++;
            $error("FAIL reset_state: %h expected %h",
                   {dvo, dtypeo, yo, uo, vo, uv_valid, meta_datao, rdyo},
                   {1'b0, 8'h00, 24'h0, 1'b0, 16'h0, 1'b1});
        end
        tick(1);
        reset = 1'b0;
        tick(1);

        // 420 frame 4x2 with header
        send_word(DT_FRAME_START, 32'h0);
        send_word(DT_HEADER_START, 32'h0);
        send_word(DT_HEADER, 32'hBEEF1234);
        send_word(DT_PIXEL, 32'h13121110);
        send_word(DT_PIXEL, 32'hB1A12120);
        send_word(DT_PIXEL, 32'hB3A32322);
        tick(25);
        send_word(DT_FRAME_END, 32'h0);
        expect_kind("t1_fs", DT_FRAME_START);
        expect_kind("t1_hs", DT_HEADER_START);
        expect_meta("t1_hdr_lo", 16'h1234);
        c0 = last_cyc;
        expect_meta("t1_hdr_hi", 16'hBEEF);
        checks++;
        assert (last_cyc === c0 + 32'd1) else begin
            errors++;
            $error("FAIL t1_hdr_consec: cycle %0d expected %0d", last_cyc, c0 + 32'd1);
        end
        expect_kind("t1_rs0", DT_ROW_START);
        expect_pix("t1_p00", 8'h10, 8'h00, 8'h00, 1'b0);
        expect_pix("t1_p01", 8'h11, 8'h00, 8'h00, 1'b0);
        expect_pix("t1_p02", 8'h12, 8'h00, 8'h00, 1'b0);
        expect_pix("t1_p03", 8'h13, 8'h00, 8'h00, 1'b0);
        expect_kind("t1_re0", DT_ROW_END);
        expect_kind("t1_rs1", DT_ROW_START);
        expect_pix("t1_p10", 8'h20, 8'h00, 8'h00, 1'b0);
        expect_pix("t1_p11", 8'h21, 8'hA1, 8'hB1, 1'b1);
        expect_pix("t1_p12", 8'h22, 8'h00, 8'h00, 1'b0);
        expect_pix("t1_p13", 8'h23, 8'hA3, 8'hB3, 1'b1);
        expect_kind("t1_re1", DT_ROW_END);
        expect_kind("t1_fe", DT_FRAME_END);
        expect_quiet("t1_quiet");

        // raw 6x1; config changes after FRAME_START must be ignored
        image_type = 16'h0000;
        num_cols = 11'd6;
        num_rows = 11'd1;
        send_word(DT_FRAME_START, 32'h0);
        image_type = 16'h0001;
        num_cols = 11'd4;
        send_word(DT_PIXEL, 32'h04030201);
        send_word(DT_PIXEL, 32'h00000605);
        tick(20);
        send_word(DT_FRAME_END, 32'h0);
        expect_kind("t2_fs", DT_FRAME_START);
        expect_kind("t2_rs", DT_ROW_START);
        for (int i = 1; i <= 6; i++) expect_pix("t2_pix", 8'(i), 8'h00, 8'h00, 1'b0);
        expect_kind("t2_re", DT_ROW_END);
        expect_kind("t2_fe", DT_FRAME_END);
        expect_quiet("t2_quiet");

        // full YUV 4x1 (enable=0)
        image_type = 16'h0001;
        enable = 1'b0;
        num_cols = 11'd4;
        num_rows = 11'd1;
        send_word(DT_FRAME_START, 32'h0);
        low0 = rdy_low_cnt;
        send_word(DT_PIXEL, 32'h31504030);
        send_word(DT_PIXEL, 32'h42325141);
        send_word(DT_PIXEL, 32'h53433352);
        checks++;
        assert ((rdy_low_cnt > low0) === 1'b1) else begin
            errors++;
            $error("FAIL t3_rdyo_low: low cycles %0d expected >0", rdy_low_cnt - low0);
        end
        tick(20);
        send_word(DT_FRAME_END, 32'h0);
        expect_kind("t3_fs", DT_FRAME_START);
        expect_kind("t3_rs", DT_ROW_START);
        for (int i = 0; i < 4; i++) expect_pix("t3_pix", 8'(8'h30 + i), 8'(8'h40 + i), 8'(8'h50 + i), 1'b1);
        expect_kind("t3_re", DT_ROW_END);
        expect_kind("t3_fe", DT_FRAME_END);
        expect_quiet("t3_quiet");

        // short frame: 5 of 8 pixels, then FRAME_END
        num_rows = 11'd2;
        send_word(DT_FRAME_START, 32'h0);
        send_word(DT_PIXEL, 32'h61807060);
        send_word(DT_PIXEL, 32'h72628171);
        send_word(DT_PIXEL, 32'h83736382);
        send_word(DT_PIXEL, 32'hFF847464);
        send_word(DT_FRAME_END, 32'h0);
        expect_kind("t4_fs", DT_FRAME_START);
        expect_kind("t4_rs0", DT_ROW_START);
        for (int i = 0; i < 4; i++) expect_pix("t4_pix", 8'(8'h60 + i), 8'(8'h70 + i), 8'(8'h80 + i), 1'b1);
        expect_kind("t4_re0", DT_ROW_END);
        expect_kind("t4_rs1", DT_ROW_START);
        expect_pix("t4_p4", 8'h64, 8'h74, 8'h84, 1'b1);
        expect_kind("t4_re1", DT_ROW_END);
        expect_kind("t4_fe", DT_FRAME_END);
        expect_quiet("t4_quiet");
        send_word(DT_PIXEL, 32'h01020304);
        expect_quiet("t4_idle");

        // reset mid-row, then a fresh raw 2x1 frame
        image_type = 16'h0001;
        enable = 1'b1;
        num_cols = 11'd4;
        num_rows = 11'd2;
        send_word(DT_FRAME_START, 32'h0);
        send_word(DT_PIXEL, 32'h13121110);
        tick(3);
        reset = 1'b1;
        #1;
        checks++;
        assert ({dvo, dtypeo, yo, uo, vo, uv_valid, meta_datao, rdyo} === {1'b0, 8'h00, 24'h0, 1'b0, 16'h0, 1'b1})
        else begin
            errors++;
            $error("FAIL t5_reset: %h expected %h",
                   {dvo, dtypeo, yo, uo, vo, uv_valid, meta_datao, rdyo},
                   {1'b0, 8'h00, 24'h0, 1'b0, 16'h0, 1'b1});
        end
        tick(2);
        reset = 1'b0;
        rd_ptr = evq.size();
        image_type = 16'h0000;
        num_cols = 11'd2;
        num_rows = 11'd1;
        send_word(DT_FRAME_START, 32'h0);
        send_word(DT_PIXEL, 32'h5A5ABBAA);
        tick(10);
        send_word(DT_FRAME_END, 32'h0);
        expect_kind("t5_fs", DT_FRAME_START);
        expect_kind("t5_rs", DT_ROW_START);
        expect_pix("t5_p0", 8'hAA, 8'h00, 8'h00, 1'b0);
        expect_pix("t5_p1", 8'hBB, 8'h00, 8'h00, 1'b0);
        expect_kind("t5_re", DT_ROW_END);
        expect_kind("t5_fe", DT_FRAME_END);
        expect_quiet("t5_quiet");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
